// File: rtl/rst_sequencer.sv
// rst_sequencer: staged reset-release sequencer with a small register interface.
// All N_RST active-low resets are held asserted. They are then released one per
// stage, starting with bit 0, and HOLD extra cycles pass between stages.

`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif

module rst_sequencer #(
    parameter int N_RST     = 4,
    parameter int CNT_WIDTH = 8,
    parameter int HOLD_RST  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [N_RST-1:0]          rst_ob,
    input  logic [1:0]                addr,
    input  logic                      w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] acc,
    output logic [`BUS_WIDTH-1:0]     rdata,
    input  logic [`BUS_WIDTH-1:0]     wdata,
    input  logic                      req,
    output logic                      resp,
    output logic                      fault
);
    localparam int                   BW        = `BUS_WIDTH;
    localparam int                   SW        = 4;
    localparam logic [SW-1:0]        LAST      = SW'(N_RST - 1);
    localparam logic [SW-1:0]        NSTG      = SW'(N_RST);
    localparam logic [CNT_WIDTH-1:0] HOLD_INIT = CNT_WIDTH'(HOLD_RST);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, hold_q;
    logic [N_RST-1:0]     ob_d;
    logic                 busy, invld, acc_ok, start, wr_hold;
    logic [4:0]           status;
    logic [BW-1:0]        rd_val;

    // Decode the bus access: find illegal requests and form the read mux.
    always_comb begin
        busy    = (state_q == RUN);
        invld   = (addr == 2'd3)
                | (acc != `BUS_ACC_WIDTH'(`BUS_ACC_1B))
                | ((addr == 2'd0) & ~w_rb)
                | ((addr == 2'd1) & w_rb)
                | ((addr == 2'd0) & w_rb & wdata[0] & busy)
                | ((addr == 2'd2) & w_rb & busy);
        acc_ok  = req & ~invld;
        start   = acc_ok & w_rb & (addr == 2'd0) & wdata[0];
        wr_hold = acc_ok & w_rb & (addr == 2'd2);
        // While idle, stage reads N_RST, which means every reset is released.
        status  = {busy, busy ? stage_q : NSTG};
        rd_val  = '0;
        if (addr == 2'd1)      rd_val = BW'(status);
        else if (addr == 2'd2) rd_val = BW'(hold_q);
    end

    assign fault = req & invld;

    // Sequencer next state: count the hold down, then release one reset bit.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        ob_d    = rst_ob;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    cnt_d   = hold_q;
                    ob_d    = '0;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    for (int k = 0; k < N_RST; k++)
                        if (stage_q == SW'(k)) ob_d[k] = 1'b1;
                    stage_d = stage_q + 1'b1;
                    // HOLD cannot change while busy, so hold_q is still the start value.
                    cnt_d   = hold_q;
                    if (stage_q == LAST) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and HOLD register state. Reset re-arms a full run with HOLD_RST.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            stage_q <= '0;
            cnt_q   <= HOLD_INIT;
            hold_q  <= HOLD_INIT;
            rst_ob  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            rst_ob  <= ob_d;
            if (wr_hold) hold_q <= wdata[CNT_WIDTH-1:0];
        end
    end

    // Registered bus response. Read data is only non-zero alongside a read resp.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp  <= 1'b0;
            rdata <= '0;
        end else begin
            resp  <= acc_ok;
            rdata <= (acc_ok & ~w_rb) ? rd_val : '0;
        end
    end
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: randomized scenarios checked against a timing-formula model.
// The model sets bit k of rst_ob from cycle T0+(k+1)*(H+1) onwards.

`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif

module tb_rst_sequencer;
    localparam int N  = 4;
    localparam int HR = 8;
    localparam int FAR = 1 << 30;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] rst_ob;
    logic [1:0]   addr = '0;
    logic         w_rb = 1'b0;
    logic [1:0]   acc = '0;
    logic [7:0]   rdata;
    logic [7:0]   wdata = '0;
    logic         req = 1'b0;
    logic         resp, fault;

    int cyc = 0;
    int t0 = FAR, h = HR, hold_m = HR;
    int checks = 0, failures = 0;

    rst_sequencer #(.N_RST(N), .CNT_WIDTH(8), .HOLD_RST(HR)) dut (
        .clk(clk), .rst(rst), .rst_ob(rst_ob), .addr(addr), .w_rb(w_rb),
        .acc(acc), .rdata(rdata), .wdata(wdata), .req(req), .resp(resp),
        .fault(fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: bit k is released once (k+1)*(H+1) cycles have passed since T0.
    function automatic logic [N-1:0] exp_ob(int c);
        exp_ob = '0;
        for (int k = 0; k < N; k++)
            if (c >= t0 + (k + 1) * (h + 1)) exp_ob[k] = 1'b1;
    endfunction

    function automatic logic [7:0] exp_status(int c);
        logic [N-1:0] o;
        o = exp_ob(c);
        return {3'b000, (c < t0 + N * (h + 1)), 4'($countones(o))};
    endfunction

    function automatic logic exp_busy(int c);
        return c < t0 + N * (h + 1);
    endfunction

    // Issue one request cycle, then sample the response on the following cycle.
    task automatic bus(input logic [1:0] a, input logic w, input logic [1:0] ac,
                       input logic [7:0] wd, output logic f, output logic r,
                       output logic [7:0] d, output logic [N-1:0] ob, output int c);
        @(negedge clk);
        addr = a; w_rb = w; acc = ac; wdata = wd; req = 1'b1;
        #1 f = fault; c = cyc;
        @(negedge clk);
        req = 1'b0; r = resp; d = rdata; ob = rst_ob;
    endtask

    task automatic test_reset();
        logic f, r; logic [7:0] d; logic [N-1:0] ob; int c;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            checks++;
            if (rst_ob !== '0 || resp !== 1'b0 || rdata !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold rst_ob=%b resp=%b rdata=%h exp 0/0/00", rst_ob, resp, rdata);
            end
        end
        @(negedge clk); rst = 1'b0; t0 = cyc; h = HR; hold_m = HR;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #2;
            checks++;
            if (rst_ob !== exp_ob(cyc)) begin
                failures++;
                $display("FAIL reset_seq cyc=%0d rst_ob=%b exp=%b", cyc - t0, rst_ob, exp_ob(cyc));
            end
        end
        bus(2'd1, 1'b0, 2'd0, 8'h00, f, r, d, ob, c);
        checks++;
        if (f !== 1'b0 || r !== 1'b1 || d !== exp_status(c) || d !== 8'h04) begin
            failures++;
            $display("FAIL status_after_reset f=%b r=%b d=%h exp 0/1/%h", f, r, d, exp_status(c));
        end
    endtask

    task automatic test_hold0();
        logic f, r; logic [7:0] d; logic [N-1:0] ob; int c;
        bus(2'd2, 1'b1, 2'd0, 8'h00, f, r, d, ob, c);
        hold_m = 0;
        checks++;
        if (f !== 1'b0 || r !== 1'b1 || d !== 8'h00) begin
            failures++;
            $display("FAIL hold0_write f=%b r=%b d=%h exp 0/1/00", f, r, d);
        end
        bus(2'd0, 1'b1, 2'd0, 8'h01, f, r, d, ob, c);
        t0 = c + 1; h = hold_m;
        checks++;
        if (f !== 1'b0 || r !== 1'b1 || ob !== exp_ob(c + 1)) begin
            failures++;
            $display("FAIL hold0_start f=%b r=%b rst_ob=%b exp 0/1/%b", f, r, ob, exp_ob(c + 1));
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            checks++;
            if (rst_ob !== exp_ob(cyc)) begin
                failures++;
                $display("FAIL hold0_seq cyc=%0d rst_ob=%b exp=%b", cyc - t0, rst_ob, exp_ob(cyc));
            end
        end
    endtask

    task automatic test_start_busy();
        logic f, r; logic [7:0] d; logic [N-1:0] ob; int c;
        logic [7:0] hv;
        hv = 8'($urandom_range(2, 5));
        bus(2'd2, 1'b1, 2'd0, hv, f, r, d, ob, c);
        hold_m = int'(hv);
        bus(2'd0, 1'b1, 2'd0, 8'h01, f, r, d, ob, c);
        t0 = c + 1; h = hold_m;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus(2'd0, 1'b1, 2'd0, 8'h01, f, r, d, ob, c);
        checks++;
        if (f !== exp_busy(c) || r !== ~exp_busy(c)) begin
            failures++;
            $display("FAIL start_busy f=%b r=%b exp %b/%b", f, r, exp_busy(c), ~exp_busy(c));
        end
        bus(2'd2, 1'b1, 2'd0, 8'h33, f, r, d, ob, c);
        checks++;
        if (f !== 1'b1 || r !== 1'b0) begin
            failures++;
            $display("FAIL hold_wr_busy f=%b r=%b exp 1/0", f, r);
        end
        bus(2'd1, 1'b0, 2'd0, 8'h00, f, r, d, ob, c);
        checks++;
        if (f !== 1'b0 || r !== 1'b1 || d !== exp_status(c)) begin
            failures++;
            $display("FAIL status_busy f=%b r=%b d=%h exp 0/1/%h", f, r, d, exp_status(c));
        end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #2;
            checks++;
            if (rst_ob !== exp_ob(cyc)) begin
                failures++;
                $display("FAIL busy_seq cyc=%0d rst_ob=%b exp=%b", cyc - t0, rst_ob, exp_ob(cyc));
            end
        end
        bus(2'd2, 1'b0, 2'd0, 8'h00, f, r, d, ob, c);
        checks++;
        if (r !== 1'b1 || d !== 8'(hold_m)) begin
            failures++;
            $display("FAIL hold_kept r=%b d=%h exp 1/%h", r, d, 8'(hold_m));
        end
    endtask

    task automatic test_mid_reset();
        logic f, r; logic [7:0] d; logic [N-1:0] ob; int c;
        bus(2'd2, 1'b1, 2'd0, 8'h03, f, r, d, ob, c);
        hold_m = 3;
        bus(2'd0, 1'b1, 2'd0, 8'h01, f, r, d, ob, c);
        t0 = c + 1; h = hold_m;
        for (int i = 0; i < 12 && cyc < t0 + 2 * (h + 1); i++) begin
            @(posedge clk); #2;
        end
        checks++;
        if (rst_ob !== exp_ob(cyc) || rst_ob !== 4'b0011) begin
            failures++;
            $display("FAIL stage2_reached rst_ob=%b exp=0011", rst_ob);
        end
        // rst together with a legal read: reset must win, no resp.
        @(negedge clk);
        rst = 1'b1; t0 = FAR;
        addr = 2'd1; w_rb = 1'b0; acc = 2'd0; req = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (rst_ob !== '0 || resp !== 1'b0 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset rst_ob=%b resp=%b rdata=%h exp 0/0/00", rst_ob, resp, rdata);
        end
        @(negedge clk); req = 1'b0;
        @(negedge clk); rst = 1'b0; t0 = cyc; h = HR; hold_m = HR;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            checks++;
            if (rst_ob !== exp_ob(cyc)) begin
                failures++;
                $display("FAIL rerun_seq cyc=%0d rst_ob=%b exp=%b", cyc - t0, rst_ob, exp_ob(cyc));
            end
        end
        bus(2'd2, 1'b0, 2'd0, 8'h00, f, r, d, ob, c);
        checks++;
        if (r !== 1'b1 || d !== 8'(HR)) begin
            failures++;
            $display("FAIL hold_after_rst r=%b d=%h exp 1/%h", r, d, 8'(HR));
        end
    endtask

    task automatic test_faults();
        logic f, r; logic [7:0] d; logic [N-1:0] ob; int c;
        logic [1:0] ta [5] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        logic       tw [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0] tc [5] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd2};
        for (int i = 0; i < 5; i++) begin
            bus(ta[i], tw[i], tc[i], 8'($urandom), f, r, d, ob, c);
            checks++;
            if (f !== 1'b1 || r !== 1'b0 || d !== 8'h00) begin
                failures++;
                $display("FAIL fault_%0d f=%b r=%b d=%h exp 1/0/00", i, f, r, d);
            end
        end
        bus(2'd2, 1'b0, 2'd0, 8'h00, f, r, d, ob, c);
        checks++;
        if (r !== 1'b1 || d !== 8'(hold_m) || ob !== exp_ob(c + 1)) begin
            failures++;
            $display("FAIL fault_no_effect d=%h rst_ob=%b exp %h/%b", d, ob, 8'(hold_m), exp_ob(c + 1));
        end
    endtask

    task automatic test_hold_rw();
        logic f, r; logic [7:0] d; logic [N-1:0] ob; int c;
        logic [7:0] hv;
        bus(2'd2, 1'b1, 2'd0, 8'h05, f, r, d, ob, c);
        hold_m = 5;
        bus(2'd2, 1'b0, 2'd0, 8'h00, f, r, d, ob, c);
        checks++;
        if (f !== 1'b0 || r !== 1'b1 || d !== 8'h05) begin
            failures++;
            $display("FAIL hold_rw f=%b r=%b d=%h exp 0/1/05", f, r, d);
        end
        bus(2'd0, 1'b1, 2'd0, 8'h00, f, r, d, ob, c);
        checks++;
        if (f !== 1'b0 || r !== 1'b1 || ob !== exp_ob(c + 1)) begin
            failures++;
            $display("FAIL ctrl_noop f=%b r=%b rst_ob=%b exp 0/1/%b", f, r, ob, exp_ob(c + 1));
        end
        for (int it = 0; it < 3; it++) begin
            hv = 8'($urandom_range(0, 4));
            bus(2'd2, 1'b1, 2'd0, hv, f, r, d, ob, c);
            hold_m = int'(hv);
            bus(2'd0, 1'b1, 2'd0, 8'h01, f, r, d, ob, c);
            t0 = c + 1; h = hold_m;
            checks++;
            if (r !== 1'b1 || ob !== exp_ob(c + 1)) begin
                failures++;
                $display("FAIL rand_start_%0d r=%b rst_ob=%b exp 1/%b", it, r, ob, exp_ob(c + 1));
            end
            for (int i = 0; i < N * (h + 1) + 2; i++) begin
                @(posedge clk); #2;
                checks++;
                if (rst_ob !== exp_ob(cyc)) begin
                    failures++;
                    $display("FAIL rand_seq_%0d cyc=%0d rst_ob=%b exp=%b", it, cyc - t0, rst_ob, exp_ob(cyc));
                end
            end
            bus(2'd1, 1'b0, 2'd0, 8'h00, f, r, d, ob, c);
            checks++;
            if (r !== 1'b1 || d !== exp_status(c)) begin
                failures++;
                $display("FAIL rand_status_%0d d=%h exp=%h", it, d, exp_status(c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold0();
        test_start_busy();
        test_mid_reset();
        test_faults();
        test_hold_rw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
